// File: rtl/dv_mem_pkg.sv
// Shared constants and helpers for the dual-port behavioural memory model.
package dv_mem_pkg;

  localparam int RDW_OLD    = 0;
  localparam int RDW_NEW    = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic int calc_nb(input int dw, input int bw);
    return dw / bw;
  endfunction

endpackage

// File: rtl/dv_mem_rd_pipe.sv
// Read-return pipeline: RD_LAT stages of valid+data, the last stage doubling
// as the output register that holds its value between reads.
module dv_mem_rd_pipe
  import dv_mem_pkg::*;
#(
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_vld_i,
  input  logic [DW-1:0] rd_data_i,
  output logic          rvalid_o,
  output logic [DW-1:0] dout_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;
  logic [DW-1:0]     dat_q [RD_LAT];
  logic [DW-1:0]     dat_d [RD_LAT];

  always_comb begin
    vld_d    = '0;
    vld_d[0] = rd_vld_i;
    dat_d[0] = rd_data_i;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Data stages only load with a valid entry, so the last stage holds the
  // most recent returned word while no read is completing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        if (vld_d[i]) dat_q[i] <= dat_d[i];
      end
    end
  end

  assign rvalid_o = vld_q[RD_LAT-1];
  assign dout_o   = dat_q[RD_LAT-1];

endmodule

// File: rtl/dv_mem_model_dp.sv
// True dual-port behavioural memory with byte-lane writes, per-port read
// latency pipelines, cross-port read-during-write select and collision flag.
module dv_mem_model_dp
  import dv_mem_pkg::*;
#(
  parameter int  DW       = 16,
  parameter int  AW       = 20,
  parameter int  BW       = 8,
  parameter int  RD_LAT   = 1,
  parameter int  RDW_MODE = RDW_OLD,
  localparam int NB       = calc_nb(DW, BW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [NB-1:0] a_be,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic          a_rvalid,
  output logic [DW-1:0] a_dout,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [NB-1:0] b_be,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic          b_rvalid,
  output logic [DW-1:0] b_dout,
  output logic          coll_err
);

  if ((DW % BW) != 0) begin : g_chk_dw
    $fatal(1, "dv_mem_model_dp: DW must be a multiple of BW");
  end
  if ((RD_LAT < 1) || (RD_LAT > RD_LAT_MAX)) begin : g_chk_lat
    $fatal(1, "dv_mem_model_dp: RD_LAT must be within 1..4");
  end

  logic [DW-1:0] mem_q [2**AW];
  logic          coll_q, coll_d;
  logic          a_act, b_act, a_wr, b_wr, a_rd, b_rd, same_addr;
  logic [DW-1:0] a_word, b_word, a_rdata, b_rdata;

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] base,
                                               input logic [DW-1:0] wdata,
                                               input logic [NB-1:0] be);
    logic [DW-1:0] res;
    res = base;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[i*BW +: BW] = wdata[i*BW +: BW];
    end
    return res;
  endfunction

  // An unknown request is treated as no request at all.
  assign a_act     = (a_req === 1'b1);
  assign b_act     = (b_req === 1'b1);
  assign a_wr      = a_act & a_we & (|a_be);
  assign b_wr      = b_act & b_we & (|b_be);
  assign a_rd      = a_act & ~a_we;
  assign b_rd      = b_act & ~b_we;
  assign same_addr = (a_addr == b_addr);

  // A's word is merged on top of B's when both hit one address, giving A
  // priority on shared lanes while B-only lanes survive.
  assign b_word = lane_merge(mem_q[b_addr], b_din, b_be);
  assign a_word = lane_merge((b_wr && same_addr) ? b_word : mem_q[a_addr], a_din, a_be);

  assign a_rdata = ((RDW_MODE == RDW_NEW) && b_wr && same_addr) ? b_word : mem_q[a_addr];
  assign b_rdata = ((RDW_MODE == RDW_NEW) && a_wr && same_addr) ? a_word : mem_q[b_addr];

  always_ff @(posedge clk) begin
    if (b_wr) mem_q[b_addr] <= b_word;
    if (a_wr) mem_q[a_addr] <= a_word;
  end

  assign coll_d = coll_q | (a_wr & b_wr & same_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll_q <= 1'b0;
    else        coll_q <= coll_d;
  end

  assign coll_err = coll_q;

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(a_req)) else $error("dv_mem_model_dp: a_req is X/Z");
      assert (!$isunknown(b_req)) else $error("dv_mem_model_dp: b_req is X/Z");
    end
  end

  dv_mem_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_rd_pipe_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_vld_i (a_rd),
    .rd_data_i(a_rdata),
    .rvalid_o (a_rvalid),
    .dout_o   (a_dout)
  );

  dv_mem_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_rd_pipe_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_vld_i (b_rd),
    .rd_data_i(b_rdata),
    .rvalid_o (b_rvalid),
    .dout_o   (b_dout)
  );

endmodule

// File: tb/tb_dv_mem_model_dp.sv
// Bench for dv_mem_model_dp: four instances (RD_LAT 1..4, alternating RDW
// mode) share one stimulus stream and are checked against a memory model.
module tb_dv_mem_model_dp;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int BW   = 8;
  localparam int NB   = 2;
  localparam int NDUT = 4;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          aReq, aWe, bReq, bWe;
  logic [NB-1:0] aBe, bBe;
  logic [AW-1:0] aAddr, bAddr;
  logic [DW-1:0] aDin, bDin;
  logic          aRvalid [NDUT];
  logic          bRvalid [NDUT];
  logic [DW-1:0] aDout   [NDUT];
  logic [DW-1:0] bDout   [NDUT];
  logic          collErr [NDUT];

  int nCompared = 0;
  int nMismatched = 0;

  // Reference model: plain word array plus an 8-entry history of the reads
  // issued each cycle, holding both the pre-write and post-write word.
  logic [DW-1:0] memM [256];
  int            cyc = 0;
  logic          hvA [8];
  logic          hvB [8];
  logic [DW-1:0] hOldA [8], hNewA [8], hOldB [8], hNewB [8];
  logic          expAv [NDUT], expBv [NDUT];
  logic [DW-1:0] expAd [NDUT], expBd [NDUT];
  logic          expColl;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    dv_mem_model_dp #(.DW(DW), .AW(AW), .BW(BW), .RD_LAT(g + 1), .RDW_MODE(g % 2)) uDut (
      .clk     (clk),
      .rst_n   (rstN),
      .a_req   (aReq),
      .a_we    (aWe),
      .a_be    (aBe),
      .a_addr  (aAddr),
      .a_din   (aDin),
      .a_rvalid(aRvalid[g]),
      .a_dout  (aDout[g]),
      .b_req   (bReq),
      .b_we    (bWe),
      .b_be    (bBe),
      .b_addr  (bAddr),
      .b_din   (bDin),
      .b_rvalid(bRvalid[g]),
      .b_dout  (bDout[g]),
      .coll_err(collErr[g])
    );
  end

  function automatic int latOf(input int k);
    return k + 1;
  endfunction

  function automatic bit modeNew(input int k);
    return (k % 2) == 1;
  endfunction

  task automatic setIdle();
    aReq = 1'b0; aWe = 1'b0; aBe = '0; aAddr = '0; aDin = '0;
    bReq = 1'b0; bWe = 1'b0; bBe = '0; bAddr = '0; bDin = '0;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin
      hvA[i] = 1'b0; hvB[i] = 1'b0;
      hOldA[i] = '0; hNewA[i] = '0; hOldB[i] = '0; hNewB[i] = '0;
    end
    for (int k = 0; k < NDUT; k++) begin
      expAv[k] = 1'b0; expBv[k] = 1'b0; expAd[k] = '0; expBd[k] = '0;
    end
    expColl = 1'b0;
  endtask

  // Advance one clock edge, apply that edge's traffic to the model, then
  // move 1 time unit past the edge so outputs can be sampled.
  task automatic step();
    logic          aWr, bWr;
    logic [DW-1:0] oldA, oldB;
    int            s, idx;
    @(posedge clk);
    cyc++;
    if (!rstN) begin
      modelReset();
    end else begin
      aWr  = aReq && aWe && (aBe != '0);
      bWr  = bReq && bWe && (bBe != '0);
      oldA = memM[aAddr];
      oldB = memM[bAddr];
      for (int i = 0; i < NB; i++) begin
        if (bWr && bBe[i]) memM[bAddr][i*BW +: BW] = bDin[i*BW +: BW];
      end
      for (int i = 0; i < NB; i++) begin
        if (aWr && aBe[i]) memM[aAddr][i*BW +: BW] = aDin[i*BW +: BW];
      end
      if (aWr && bWr && (aAddr == bAddr)) expColl = 1'b1;
      s = cyc % 8;
      hvA[s] = aReq && !aWe; hOldA[s] = oldA; hNewA[s] = memM[aAddr];
      hvB[s] = bReq && !bWe; hOldB[s] = oldB; hNewB[s] = memM[bAddr];
      for (int k = 0; k < NDUT; k++) begin
        idx = (cyc - latOf(k) + 1 + 8) % 8;
        expAv[k] = hvA[idx];
        expBv[k] = hvB[idx];
        if (hvA[idx]) expAd[k] = modeNew(k) ? hNewA[idx] : hOldA[idx];
        if (hvB[idx]) expBd[k] = modeNew(k) ? hNewB[idx] : hOldB[idx];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    modelReset();
    repeat (3) step();
    for (int k = 0; k < NDUT; k++) begin
      nCompared++;
      if (aRvalid[k] !== 1'b0 || bRvalid[k] !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL reset_rvalid dut%0d: a=%b b=%b, expected 0 0", k, aRvalid[k], bRvalid[k]);
      end
      nCompared++;
      if (aDout[k] !== 16'h0000 || bDout[k] !== 16'h0000) begin
        nMismatched++;
        $display("[TB] FAIL reset_dout dut%0d: a=%h b=%h, expected 0000 0000", k, aDout[k], bDout[k]);
      end
      nCompared++;
      if (collErr[k] !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL reset_coll dut%0d: coll_err=%b, expected 0", k, collErr[k]);
      end
    end
    rstN = 1'b1;
    step();
  endtask

  task automatic preload();
    for (int i = 0; i < 128; i++) begin
      aReq = 1'b1; aWe = 1'b1; aBe = 2'b11; aAddr = 8'(i);       aDin = 16'($urandom);
      bReq = 1'b1; bWe = 1'b1; bBe = 2'b11; bAddr = 8'(i + 128); bDin = 16'($urandom);
      step();
    end
    setIdle();
    step();
  endtask

  task automatic test_be_merge();
    for (int c = 0; c < 8; c++) begin
      setIdle();
      case (c)
        0: begin aReq = 1'b1; aWe = 1'b1; aBe = 2'b11; aAddr = 8'h10; aDin = 16'h1234; end
        1: begin aReq = 1'b1; aWe = 1'b1; aBe = 2'b01; aAddr = 8'h10; aDin = 16'hABCD; end
        2: begin aReq = 1'b1; aWe = 1'b0; aAddr = 8'h10; end
        default: ;
      endcase
      step();
      for (int k = 0; k < NDUT; k++) begin
        nCompared++;
        if (aRvalid[k] !== expAv[k] || aDout[k] !== expAd[k]) begin
          nMismatched++;
          $display("[TB] FAIL be_merge portA dut%0d c%0d: rvalid=%b dout=%h, expected %b %h", k, c, aRvalid[k], aDout[k], expAv[k], expAd[k]);
        end
        nCompared++;
        if (bRvalid[k] !== expBv[k]) begin
          nMismatched++;
          $display("[TB] FAIL be_merge portB dut%0d c%0d: rvalid=%b, expected %b", k, c, bRvalid[k], expBv[k]);
        end
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      nCompared++;
      if (aDout[k] !== 16'h12CD) begin
        nMismatched++;
        $display("[TB] FAIL be_merge_value dut%0d: a_dout=%h, expected 12cd", k, aDout[k]);
      end
    end
  endtask

  task automatic test_latency();
    int firstSeen [NDUT];
    int seen [NDUT];
    for (int k = 0; k < NDUT; k++) begin firstSeen[k] = -1; seen[k] = 0; end
    for (int c = 0; c < 9; c++) begin
      setIdle();
      if (c < 4) begin bReq = 1'b1; bWe = 1'b0; bAddr = 8'(c); end
      step();
      for (int k = 0; k < NDUT; k++) begin
        if (bRvalid[k] === 1'b1) begin
          seen[k]++;
          if (firstSeen[k] < 0) firstSeen[k] = c;
        end
        nCompared++;
        if (bRvalid[k] !== expBv[k] || bDout[k] !== expBd[k]) begin
          nMismatched++;
          $display("[TB] FAIL latency portB dut%0d c%0d: rvalid=%b dout=%h, expected %b %h", k, c, bRvalid[k], bDout[k], expBv[k], expBd[k]);
        end
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      nCompared++;
      if (firstSeen[k] != latOf(k) - 1 || seen[k] != 4) begin
        nMismatched++;
        $display("[TB] FAIL latency_window dut%0d: first=%0d count=%0d, expected first=%0d count=4", k, firstSeen[k], seen[k], latOf(k) - 1);
      end
      nCompared++;
      if (bDout[k] !== memM[3]) begin
        nMismatched++;
        $display("[TB] FAIL latency_hold dut%0d: b_dout=%h, expected %h", k, bDout[k], memM[3]);
      end
    end
  endtask

  task automatic test_rdw();
    for (int c = 0; c < 9; c++) begin
      setIdle();
      case (c)
        0: begin
          aReq = 1'b1; aWe = 1'b1; aBe = 2'b11; aAddr = 8'h20; aDin = 16'h0000;
          bReq = 1'b1; bWe = 1'b1; bBe = 2'b11; bAddr = 8'h21; bDin = 16'h00FF;
        end
        1: begin
          aReq = 1'b1; aWe = 1'b1; aBe = 2'b11; aAddr = 8'h20; aDin = 16'hFFFF;
          bReq = 1'b1; bWe = 1'b0; bAddr = 8'h20;
        end
        2: begin
          bReq = 1'b1; bWe = 1'b1; bBe = 2'b10; bAddr = 8'h21; bDin = 16'h5A5A;
          aReq = 1'b1; aWe = 1'b0; aAddr = 8'h21;
        end
        default: ;
      endcase
      step();
      for (int k = 0; k < NDUT; k++) begin
        nCompared++;
        if (aRvalid[k] !== expAv[k] || aDout[k] !== expAd[k]) begin
          nMismatched++;
          $display("[TB] FAIL rdw portA dut%0d c%0d: rvalid=%b dout=%h, expected %b %h", k, c, aRvalid[k], aDout[k], expAv[k], expAd[k]);
        end
        nCompared++;
        if (bRvalid[k] !== expBv[k] || bDout[k] !== expBd[k]) begin
          nMismatched++;
          $display("[TB] FAIL rdw portB dut%0d c%0d: rvalid=%b dout=%h, expected %b %h", k, c, bRvalid[k], bDout[k], expBv[k], expBd[k]);
        end
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      nCompared++;
      if (bDout[k] !== (modeNew(k) ? 16'hFFFF : 16'h0000)) begin
        nMismatched++;
        $display("[TB] FAIL rdw_b_reads_a dut%0d: b_dout=%h, expected %h", k, bDout[k], modeNew(k) ? 16'hFFFF : 16'h0000);
      end
      nCompared++;
      if (aDout[k] !== (modeNew(k) ? 16'h5AFF : 16'h00FF)) begin
        nMismatched++;
        $display("[TB] FAIL rdw_a_reads_b dut%0d: a_dout=%h, expected %h", k, aDout[k], modeNew(k) ? 16'h5AFF : 16'h00FF);
      end
    end
  endtask

  task automatic test_collision();
    for (int c = 0; c < 108; c++) begin
      setIdle();
      case (c)
        0: begin
          aReq = 1'b1; aWe = 1'b1; aBe = 2'b00; aAddr = 8'h30; aDin = 16'h9999;
          bReq = 1'b1; bWe = 1'b1; bBe = 2'b11; bAddr = 8'h30; bDin = 16'h0000;
        end
        1: begin
          aReq = 1'b1; aWe = 1'b1; aBe = 2'b10; aAddr = 8'h30; aDin = 16'h1111;
          bReq = 1'b1; bWe = 1'b1; bBe = 2'b11; bAddr = 8'h30; bDin = 16'h2222;
        end
        2: begin aReq = 1'b1; aWe = 1'b0; aAddr = 8'h30; end
        default: ;
      endcase
      step();
      for (int k = 0; k < NDUT; k++) begin
        nCompared++;
        if (aRvalid[k] !== expAv[k] || aDout[k] !== expAd[k]) begin
          nMismatched++;
          $display("[TB] FAIL collision portA dut%0d c%0d: rvalid=%b dout=%h, expected %b %h", k, c, aRvalid[k], aDout[k], expAv[k], expAd[k]);
        end
        nCompared++;
        if (collErr[k] !== expColl) begin
          nMismatched++;
          $display("[TB] FAIL collision_flag dut%0d c%0d: coll_err=%b, expected %b", k, c, collErr[k], expColl);
        end
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      nCompared++;
      if (aDout[k] !== 16'h1122 || collErr[k] !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL collision_final dut%0d: a_dout=%h coll_err=%b, expected 1122 1", k, aDout[k], collErr[k]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int seen [NDUT];
    for (int k = 0; k < NDUT; k++) seen[k] = 0;
    for (int c = 0; c < 10; c++) begin
      setIdle();
      if (c == 0) begin aReq = 1'b1; aWe = 1'b0; aAddr = 8'h10; end
      if (c == 2) begin rstN = 1'b0; modelReset(); #1; end
      if (c == 4) rstN = 1'b1;
      step();
      for (int k = 0; k < NDUT; k++) begin
        if (aRvalid[k] === 1'b1) seen[k]++;
        nCompared++;
        if (aRvalid[k] !== expAv[k] || aDout[k] !== expAd[k] || collErr[k] !== expColl) begin
          nMismatched++;
          $display("[TB] FAIL reset_mid_read dut%0d c%0d: rvalid=%b dout=%h coll=%b, expected %b %h %b", k, c, aRvalid[k], aDout[k], collErr[k], expAv[k], expAd[k], expColl);
        end
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      nCompared++;
      if (seen[k] != ((latOf(k) <= 2) ? 1 : 0) || aDout[k] !== 16'h0000 || collErr[k] !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL reset_flush dut%0d: rvalids=%0d a_dout=%h coll=%b, expected %0d 0000 0", k, seen[k], aDout[k], collErr[k], (latOf(k) <= 2) ? 1 : 0);
      end
    end
    for (int c = 0; c < 6; c++) begin
      setIdle();
      if (c == 0) begin aReq = 1'b1; aWe = 1'b0; aAddr = 8'h10; end
      step();
    end
    for (int k = 0; k < NDUT; k++) begin
      nCompared++;
      if (aDout[k] !== 16'h12CD) begin
        nMismatched++;
        $display("[TB] FAIL reset_retain dut%0d: a_dout=%h, expected 12cd", k, aDout[k]);
      end
    end
  endtask

  task automatic test_disjoint_collision();
    for (int c = 0; c < 7; c++) begin
      setIdle();
      case (c)
        0: begin
          aReq = 1'b1; aWe = 1'b1; aBe = 2'b01; aAddr = 8'h31; aDin = 16'h3333;
          bReq = 1'b1; bWe = 1'b1; bBe = 2'b10; bAddr = 8'h31; bDin = 16'h4444;
        end
        1: begin aReq = 1'b1; aWe = 1'b0; aAddr = 8'h31; end
        default: ;
      endcase
      step();
      for (int k = 0; k < NDUT; k++) begin
        nCompared++;
        if (aRvalid[k] !== expAv[k] || aDout[k] !== expAd[k] || collErr[k] !== expColl) begin
          nMismatched++;
          $display("[TB] FAIL disjoint dut%0d c%0d: rvalid=%b dout=%h coll=%b, expected %b %h %b", k, c, aRvalid[k], aDout[k], collErr[k], expAv[k], expAd[k], expColl);
        end
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      nCompared++;
      if (aDout[k] !== 16'h4433 || collErr[k] !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL disjoint_final dut%0d: a_dout=%h coll=%b, expected 4433 1", k, aDout[k], collErr[k]);
      end
    end
  endtask

  task automatic test_throughput();
    int aReads = 0;
    int bReads = 0;
    int aSeen [NDUT];
    int bSeen [NDUT];
    for (int k = 0; k < NDUT; k++) begin aSeen[k] = 0; bSeen[k] = 0; end
    for (int c = 0; c < 1006; c++) begin
      setIdle();
      if (c < 1000) begin
        aReq = ($urandom_range(0, 9) < 7); aWe = 1'($urandom_range(0, 1));
        aBe = 2'($urandom_range(0, 3)); aAddr = 8'($urandom_range(0, 255)); aDin = 16'($urandom);
        bReq = ($urandom_range(0, 9) < 7); bWe = 1'($urandom_range(0, 1));
        bBe = 2'($urandom_range(0, 3)); bAddr = 8'($urandom_range(0, 255)); bDin = 16'($urandom);
        if (aReq && aWe && bReq && bWe && (aAddr == bAddr)) bAddr = aAddr + 8'd1;
        if (aReq && !aWe) aReads++;
        if (bReq && !bWe) bReads++;
      end
      step();
      for (int k = 0; k < NDUT; k++) begin
        if (aRvalid[k] === 1'b1) aSeen[k]++;
        if (bRvalid[k] === 1'b1) bSeen[k]++;
        nCompared++;
        if (aRvalid[k] !== expAv[k] || aDout[k] !== expAd[k]) begin
          nMismatched++;
          $display("[TB] FAIL throughput portA dut%0d c%0d: rvalid=%b dout=%h, expected %b %h", k, c, aRvalid[k], aDout[k], expAv[k], expAd[k]);
        end
        nCompared++;
        if (bRvalid[k] !== expBv[k] || bDout[k] !== expBd[k]) begin
          nMismatched++;
          $display("[TB] FAIL throughput portB dut%0d c%0d: rvalid=%b dout=%h, expected %b %h", k, c, bRvalid[k], bDout[k], expBv[k], expBd[k]);
        end
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      nCompared++;
      if (aSeen[k] != aReads || bSeen[k] != bReads) begin
        nMismatched++;
        $display("[TB] FAIL throughput_count dut%0d: a=%0d b=%0d rvalids, expected %0d %0d", k, aSeen[k], bSeen[k], aReads, bReads);
      end
    end
  endtask

  initial begin
    setIdle();
    modelReset();
    #1;
    test_reset();
    preload();
    test_be_merge();
    test_latency();
    test_rdw();
    test_collision();
    test_reset_mid_read();
    test_disjoint_collision();
    test_throughput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
